segre_if_id_queue: RTL and testbench

- Small instruction queue between the fetch stage and the decode stage.
- Each valid fetch (instruction word + PC) is pushed into a DEPTH-entry circular FIFO; decode pops entries in order.
- Absorbs decode stalls without stalling the I-cache lookup, and back-pressures fetch when full.
- Flushes all entries on a taken branch and presents a NOP to decode whenever empty.

---
 rtl/segre_if_id_queue.sv | 81 ++++++++
 tb/tb_segre_if_id_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/segre_if_id_queue.sv
// rtl/segre_if_id_queue.sv - fetch-to-decode instruction queue with flush and NOP fill
module segre_if_id_queue #(
  parameter int                    DEPTH     = 4,
  parameter int                    WORD_SIZE = 32,
  parameter int                    ADDR_SIZE = 32,
  parameter logic [WORD_SIZE-1:0]  NOP_INSTR = 32'h00000013
) (
  input  logic                       clk_i,
  input  logic                       rsn_i,
  input  logic                       valid_if_i,
  input  logic [WORD_SIZE-1:0]       instr_i,
  input  logic [ADDR_SIZE-1:0]       pc_i,
  input  logic                       flush_i,
  input  logic                       stall_id_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       valid_id_o,
  output logic [WORD_SIZE-1:0]       instr_o,
  output logic [ADDR_SIZE-1:0]       pc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WORD_SIZE-1:0] instr_q [DEPTH];
  logic [ADDR_SIZE-1:0] pc_q    [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;

  // Status comes from the count register only; flush gates just the head outputs.
  assign full_o     = (count == FULL_CNT);
  assign empty_o    = (count == '0);
  assign count_o    = count;
  assign valid_id_o = !empty_o && !flush_i;
  assign instr_o    = valid_id_o ? instr_q[rd_ptr] : NOP_INSTR;
  assign pc_o       = valid_id_o ? pc_q[rd_ptr] : '0;

  assign push = valid_if_i && !full_o && !flush_i;
  assign pop  = valid_id_o && !stall_id_i;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only observable once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_ptr] <= instr_i;
      pc_q[wr_ptr]    <= pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      assert (count <= FULL_CNT);
      assert (PW'(wr_ptr - rd_ptr) == count[PW-1:0]);
    end
  end

endmodule

// File: tb/tb_segre_if_id_queue.sv
// tb/tb_segre_if_id_queue.sv - bench for segre_if_id_queue against a queue model
module tb_segre_if_id_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rsn_i = 1'b0;
  logic        valid_if_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_id_i = 1'b0;
  logic        full_o;
  logic        empty_o;
  logic [2:0]  count_o;
  logic        valid_id_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  segre_if_id_queue #(.DEPTH(DEPTH), .WORD_SIZE(32), .ADDR_SIZE(32), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rsn_i(rsn_i), .valid_if_i(valid_if_i), .instr_i(instr_i), .pc_i(pc_i),
    .flush_i(flush_i), .stall_id_i(stall_id_i), .full_o(full_o), .empty_o(empty_o),
    .count_o(count_o), .valid_id_o(valid_id_o), .instr_o(instr_o), .pc_o(pc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit fl, input bit st);
    valid_if_i = v;
    instr_i    = ins;
    pc_i       = pc;
    flush_i    = fl;
    stall_id_i = st;
  endtask

  task automatic check_model(input string tag);
    bit vld;
    vld = (mq.size() != 0) && !flush_i;
    chk({tag, ".count"}, 32'(count_o), 32'(mq.size()));
    chk({tag, ".full"},  32'(full_o),  32'(mq.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty_o), 32'(mq.size() == 0));
    chk({tag, ".valid"}, 32'(valid_id_o), 32'(vld));
    chk({tag, ".instr"}, instr_o, vld ? mq[0].instr : NOP);
    chk({tag, ".pc"},    pc_o,    vld ? mq[0].pc : 32'h0);
  endtask

  // Called at posedge+1 with inputs applied; checks, advances the model, returns at next posedge+1.
  task automatic tick(input string tag);
    bit   was_full;
    bit   vld;
    ent_t e;
    #3;
    check_model(tag);
    was_full = (mq.size() == DEPTH);
    vld      = (mq.size() != 0) && !flush_i;
    if (flush_i) begin
      mq.delete();
    end else begin
      if (vld && !stall_id_i) void'(mq.pop_front());
      if (valid_if_i && !was_full) begin
        e.pc    = pc_i;
        e.instr = instr_i;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, with a fetch presented that must be ignored
    set_in(1'b1, 32'hDEADBEEF, 32'h44, 1'b0, 1'b0);
    #4;
    chk("rst.count", 32'(count_o), 32'd0);
    chk("rst.empty", 32'(empty_o), 32'd1);
    chk("rst.full",  32'(full_o), 32'd0);
    chk("rst.valid", 32'(valid_id_o), 32'd0);
    chk("rst.instr", instr_o, NOP);
    chk("rst.pc",    pc_o, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_ignore.empty", 32'(empty_o), 32'd1);
    rsn_i = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill with decode stalled; fifth fetch is dropped
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h00100093 + 32'(i), 32'(i * 4), 1'b0, 1'b1);
      tick("fill");
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("fill.count4", 32'(count_o), 32'd4);
    chk("fill.full",   32'(full_o), 32'd1);
    chk("fill.head",   pc_o, 32'h0);
    tick("fill_hold");
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (4) tick("drain1");

    // One-cycle latency from an empty queue
    set_in(1'b1, 32'h00A00093, 32'h10, 1'b0, 1'b0);
    #1;
    chk("lat.n_valid", 32'(valid_id_o), 32'd0);
    chk("lat.n_instr", instr_o, NOP);
    tick("lat_n");
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("lat.n1_valid", 32'(valid_id_o), 32'd1);
    chk("lat.n1_instr", instr_o, 32'h00A00093);
    chk("lat.n1_pc",    pc_o, 32'h10);
    tick("lat_n1");
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick("drain2");

    // Steady push+pop at occupancy 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, $urandom, 32'h100 + 32'(i * 4), 1'b0, 1'b1);
      tick("ss_fill");
    end
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, $urandom, 32'h108 + 32'(i * 4), 1'b0, 1'b0);
      #1;
      chk("ss.count2", 32'(count_o), 32'd2);
      tick("ss");
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) tick("drain3");

    // Flush with a same-cycle fetch
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, $urandom, 32'h200 + 32'(i * 4), 1'b0, 1'b1);
      tick("fl_fill");
    end
    set_in(1'b1, 32'h00000001, 32'h40, 1'b1, 1'b0);
    #1;
    chk("fl.valid0", 32'(valid_id_o), 32'd0);
    tick("flush");
    set_in(1'b1, 32'h00000002, 32'h80, 1'b0, 1'b1);
    #1;
    chk("fl.count0", 32'(count_o), 32'd0);
    chk("fl.empty",  32'(empty_o), 32'd1);
    tick("fl_push");
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("fl.pc80", pc_o, 32'h80);
    tick("fl_show");
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick("drain4");

    // Full queue: pop happens, push rejected
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, $urandom, 32'h300 + 32'(i * 4), 1'b0, 1'b1);
      tick("fu_fill");
    end
    set_in(1'b1, 32'h00000003, 32'h310, 1'b0, 1'b0);
    #1;
    chk("fu.count4", 32'(count_o), 32'd4);
    tick("fu_pop");
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("fu.count3", 32'(count_o), 32'd3);
    chk("fu.notfull", 32'(full_o), 32'd0);
    chk("fu.head", pc_o, 32'h304);
    tick("fu_hold");
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) tick("drain5");

    // Asynchronous reset mid-cycle with two entries held
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, $urandom, 32'h400 + 32'(i * 4), 1'b0, 1'b1);
      tick("ar_fill");
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rsn_i = 1'b0;
    #1;
    chk("ar.count", 32'(count_o), 32'd0);
    chk("ar.valid", 32'(valid_id_o), 32'd0);
    chk("ar.instr", instr_o, NOP);
    chk("ar.pc",    pc_o, 32'h0);
    chk("ar.empty", 32'(empty_o), 32'd1);
    mq.delete();
    #2;
    rsn_i = 1'b1;
    @(posedge clk);
    #1;
    tick("ar_after");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
